// File: rtl/pkt_comm_tx.sv
// Outbound packet builder: frames a header, header checksum, body and body
// checksum as 16-bit words into the output FIFO write port.
module pkt_comm_tx #(
  parameter logic [7:0] VERSION          = 8'd2,
  parameter bit         DISABLE_CHECKSUM = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  pkt_type,
  input  logic [15:0] pkt_id,
  input  logic [23:0] pkt_len,
  output logic        busy,
  input  logic [15:0] body_din,
  input  logic        body_valid,
  output logic        body_rd,
  output logic [15:0] dout,
  output logic        wr_en,
  input  logic        full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HCSUM,
    S_BODY,
    S_BCSUM
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] id_q, id_d;
  logic [23:0] len_q, len_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] hacc_q, hacc_d;
  logic [31:0] bacc_q, bacc_d;
  logic        odd_q, odd_d;
  logic [15:0] hdr_word;

  // Checksum halves: low half is the first word on the wire.
  function automatic logic [15:0] csum_half(input logic [31:0] acc, input logic hi);
    logic [31:0] c;
    c = DISABLE_CHECKSUM ? 32'h0 : ~acc;
    return hi ? c[31:16] : c[15:0];
  endfunction

  always_comb begin
    case (idx_q)
      3'd0:    hdr_word = {type_q, VERSION};
      3'd1:    hdr_word = 16'h0000;
      3'd2:    hdr_word = len_q[15:0];
      3'd3:    hdr_word = {8'h00, len_q[23:16]};
      default: hdr_word = id_q;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case below can leave a variable unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    type_d  = type_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hacc_d  = hacc_q;
    bacc_d  = bacc_q;
    odd_d   = odd_q;
    dout    = 16'h0000;
    wr_en   = 1'b0;
    body_rd = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = 3'd0;
          type_d  = pkt_type;
          id_d    = pkt_id;
          len_d   = pkt_len & 24'hFF_FFFE;
          cnt_d   = {1'b0, pkt_len[23:1]};
          hacc_d  = 32'h0;
        end
      end

      S_HDR: begin
        dout  = hdr_word;
        wr_en = !full;
        if (!full) begin
          hacc_d = hacc_q + (idx_q[0] ? {hdr_word, 16'h0000} : {16'h0000, hdr_word});
          if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = S_HCSUM;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_HCSUM: begin
        dout  = csum_half(hacc_q, idx_q[0]);
        wr_en = !full;
        if (!full) begin
          if (idx_q[0]) begin
            idx_d   = 3'd0;
            bacc_d  = 32'h0;
            odd_d   = 1'b0;
            state_d = (cnt_q == 24'd0) ? S_BCSUM : S_BODY;
          end else begin
            idx_d = 3'd1;
          end
        end
      end

      S_BODY: begin
        dout    = body_din;
        wr_en   = body_valid && !full;
        body_rd = body_valid && !full;
        if (body_valid && !full) begin
          bacc_d = bacc_q + (odd_q ? {body_din, 16'h0000} : {16'h0000, body_din});
          odd_d  = !odd_q;
          cnt_d  = cnt_q - 24'd1;
          if (cnt_q == 24'd1) state_d = S_BCSUM;
        end
      end

      S_BCSUM: begin
        dout  = csum_half(bacc_q, idx_q[0]);
        wr_en = !full;
        if (!full) begin
          if (idx_q[0]) begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      type_q  <= 8'h00;
      id_q    <= 16'h0000;
      len_q   <= 24'h0;
      cnt_q   <= 24'h0;
      hacc_q  <= 32'h0;
      bacc_q  <= 32'h0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hacc_q  <= hacc_d;
      bacc_q  <= bacc_d;
      odd_q   <= odd_d;
    end
  end

endmodule

// File: tb/tb_pkt_comm_tx.sv
// Bench for pkt_comm_tx: directed vector table, hand-written corner sequences
// and randomized packets against a word-list reference model.
module tb_pkt_comm_tx;

  localparam logic [7:0] VER = 8'd2;

  logic        CLK = 1'b0;
  logic        RST, start, body_valid, full;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id, body_din;
  logic [23:0] pkt_len;
  logic        busy, body_rd, wr_en;
  logic [15:0] dout;
  logic        busy_nc, body_rd_nc, wr_en_nc;
  logic [15:0] dout_nc;

  always #5 CLK = ~CLK;

  pkt_comm_tx #(.VERSION(VER), .DISABLE_CHECKSUM(1'b0)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pkt_type(pkt_type), .pkt_id(pkt_id),
    .pkt_len(pkt_len), .busy(busy), .body_din(body_din), .body_valid(body_valid),
    .body_rd(body_rd), .dout(dout), .wr_en(wr_en), .full(full)
  );

  pkt_comm_tx #(.VERSION(VER), .DISABLE_CHECKSUM(1'b1)) dut_nc (
    .CLK(CLK), .RST(RST), .start(start), .pkt_type(pkt_type), .pkt_id(pkt_id),
    .pkt_len(pkt_len), .busy(busy_nc), .body_din(body_din), .body_valid(body_valid),
    .body_rd(body_rd_nc), .dout(dout_nc), .wr_en(wr_en_nc), .full(full)
  );

  typedef logic [15:0] wq_t[$];

  typedef struct {
    logic [7:0]  typ;
    logic [15:0] id;
    logic [23:0] len;
    logic [15:0] body[4];
    logic [15:0] hcs_lo, hcs_hi, bcs_lo, bcs_hi;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  wq_t  got, got_nc, exp_q, body_q;
  vec_t vecs[5];
  int   bc, rc, cnt, nw;
  logic b0, seen;
  logic [7:0]  rt;
  logic [15:0] rid;
  logic [23:0] rlen;

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, g, e);
    end
  endtask

  // Reference checksum: words paired little-half first, summed mod 2^32, inverted.
  function automatic logic [31:0] csum32(input wq_t w);
    logic [31:0] s;
    s = 32'h0;
    foreach (w[i]) s += (i % 2 == 1) ? {w[i], 16'h0000} : {16'h0000, w[i]};
    return ~s;
  endfunction

  function automatic wq_t ref_pkt(input logic [7:0] t, input logic [15:0] id,
                                  input logic [23:0] len, input wq_t body, input bit dis);
    wq_t hdr, bw, o;
    logic [23:0] le;
    logic [31:0] hc, bcs;
    le = {len[23:1], 1'b0};
    hdr.push_back({t, VER});
    hdr.push_back(16'h0000);
    hdr.push_back(le[15:0]);
    hdr.push_back({8'h00, le[23:16]});
    hdr.push_back(id);
    for (int i = 0; i < int'(le >> 1); i++) bw.push_back(body[i]);
    hc  = dis ? 32'h0 : csum32(hdr);
    bcs = dis ? 32'h0 : csum32(bw);
    o = hdr;
    o.push_back(hc[15:0]);
    o.push_back(hc[31:16]);
    foreach (bw[i]) o.push_back(bw[i]);
    o.push_back(bcs[15:0]);
    o.push_back(bcs[31:16]);
    return o;
  endfunction

  function automatic vec_t mk(input logic [7:0] t, input logic [15:0] id, input logic [23:0] len,
                              input logic [15:0] w0, w1, w2, w3, hl, hh, bl, bh);
    vec_t v;
    v.typ = t; v.id = id; v.len = len;
    v.body[0] = w0; v.body[1] = w1; v.body[2] = w2; v.body[3] = w3;
    v.hcs_lo = hl; v.hcs_hi = hh; v.bcs_lo = bl; v.bcs_hi = bh;
    return v;
  endfunction

  function automatic bit bitat(input logic [63:0] m, input int i);
    return ((m >> i) & 64'd1) != 64'd0;
  endfunction

  task automatic cmp_seq(input string name, input wq_t g, input wq_t e);
    check($sformatf("%s word count", name), g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s w%0d", name, i), g[i], e[i]);
  endtask

  // Drives one packet cycle by cycle and records every written word.
  task automatic run_pkt(input logic [7:0] t, input logic [15:0] id, input logic [23:0] len,
                         input wq_t body, input logic [63:0] start_mask, full_mask, inval_mask,
                         input int full_pct, inval_pct,
                         output int busy_cyc, output int rd_cnt, output logic busy0);
    int bidx, viol;
    bit done;
    got.delete(); got_nc.delete();
    bidx = 0; viol = 0; busy_cyc = 0; rd_cnt = 0; busy0 = 1'b0; done = 1'b0;
    for (int it = 0; it < 500 && !done; it++) begin
      @(posedge CLK); #1;
      start      = bitat(start_mask, it);
      pkt_type   = t;
      pkt_id     = id;
      pkt_len    = len;
      full       = bitat(full_mask, it) || ($urandom_range(99) < full_pct);
      body_valid = !(bitat(inval_mask, it) || ($urandom_range(99) < inval_pct));
      body_din   = (bidx < body.size()) ? body[bidx] : 16'($urandom);
      @(negedge CLK);
      if (it == 0) busy0 = busy;
      if (busy) busy_cyc++;
      if (wr_en) got.push_back(dout);
      if (wr_en_nc) got_nc.push_back(dout_nc);
      if (body_rd) begin
        rd_cnt++;
        bidx++;
      end
      if ((full && (wr_en || body_rd)) || (!body_valid && body_rd) || (body_rd && !wr_en) ||
          (wr_en != wr_en_nc) || (busy != busy_nc))
        viol++;
      if (it > 0 && !busy) done = 1'b1;
    end
    check("packet completes", done, 1'b1);
    check("stall rules", viol, 0);
  endtask

  task automatic idle_quiet(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      if (wr_en || busy || body_rd) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; full = 1'b0; body_valid = 1'b1; body_din = 16'hA5A5;
    pkt_type = 8'h00; pkt_id = 16'h0; pkt_len = 24'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset busy", busy, 1'b0);
    check("reset wr_en", wr_en, 1'b0);
    check("reset body_rd", body_rd, 1'b0);
    check("reset dout", dout, 16'h0000);
    @(posedge CLK); #1;
    RST = 1'b0;

    vecs[0] = mk(8'h03, 16'hCDAB, 24'd0, 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h2F52, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    vecs[1] = mk(8'h03, 16'hCDAB, 24'd4, 16'h1234, 16'h5678, 16'h0, 16'h0,
                 16'h2F4E, 16'hFFFF, 16'hEDCB, 16'hA987);
    vecs[2] = mk(8'h03, 16'hCDAB, 24'd6, 16'h0001, 16'h0002, 16'h0003, 16'h0,
                 16'h2F4C, 16'hFFFF, 16'hFFFB, 16'hFFFD);
    vecs[3] = mk(8'h03, 16'hCDAB, 24'd7, 16'h0001, 16'h0002, 16'h0003, 16'h0,
                 16'h2F4C, 16'hFFFF, 16'hFFFB, 16'hFFFD);
    vecs[4] = mk(8'hA5, 16'h1234, 24'd8, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                 16'h48C1, 16'hFFFF, 16'h0001, 16'h0000);

    foreach (vecs[v]) begin
      body_q.delete();
      for (int i = 0; i < 4; i++) body_q.push_back(vecs[v].body[i]);
      run_pkt(vecs[v].typ, vecs[v].id, vecs[v].len, body_q, 64'h1, 64'h0, 64'h0, 0, 0, bc, rc, b0);
      nw = int'(vecs[v].len >> 1);
      exp_q = ref_pkt(vecs[v].typ, vecs[v].id, vecs[v].len, body_q, 1'b0);
      cmp_seq($sformatf("vec%0d", v), got, exp_q);
      exp_q = ref_pkt(vecs[v].typ, vecs[v].id, vecs[v].len, body_q, 1'b1);
      cmp_seq($sformatf("vec%0d nocsum", v), got_nc, exp_q);
      if (got.size() == nw + 9) begin
        check($sformatf("vec%0d hcsum lo", v), got[5], vecs[v].hcs_lo);
        check($sformatf("vec%0d hcsum hi", v), got[6], vecs[v].hcs_hi);
        check($sformatf("vec%0d bcsum lo", v), got[nw + 7], vecs[v].bcs_lo);
        check($sformatf("vec%0d bcsum hi", v), got[nw + 8], vecs[v].bcs_hi);
      end
      check($sformatf("vec%0d busy cycles", v), bc, 9 + nw);
      check($sformatf("vec%0d body_rd count", v), rc, nw);
    end

    // Backpressure: full for three header cycles, body_valid low for two body cycles.
    body_q.delete();
    body_q.push_back(16'h1234); body_q.push_back(16'h5678);
    run_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 64'h1, 64'h1C, 64'h1800, 0, 0, bc, rc, b0);
    exp_q = ref_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 1'b0);
    cmp_seq("stall", got, exp_q);
    check("stall busy cycles", bc, 16);
    check("stall body_rd count", rc, 2);

    // start pulsed while busy must not queue a second packet.
    run_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 64'h9, 64'h0, 64'h0, 0, 0, bc, rc, b0);
    cmp_seq("start while busy", got, exp_q);
    idle_quiet("no second packet", 15);

    // Reset mid-body, with a length that exercises the upper header length byte.
    @(posedge CLK); #1;
    start = 1'b1; pkt_type = 8'h03; pkt_id = 16'hCDAB; pkt_len = 24'h020007;
    full = 1'b0; body_valid = 1'b1; body_din = 16'h1111;
    got.delete(); seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      body_din = 16'h1111 + 16'(k);
      @(negedge CLK);
      if (wr_en) got.push_back(dout);
      if (body_rd) seen = 1'b1;
    end
    check("reached body before reset", seen, 1'b1);
    exp_q.delete();
    exp_q.push_back(16'h0302); exp_q.push_back(16'h0000); exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0002); exp_q.push_back(16'hCDAB); exp_q.push_back(16'h2F4C);
    exp_q.push_back(16'hFFFD);
    check("words before reset", got.size(), 8);
    for (int i = 0; i < 7 && i < got.size(); i++)
      check($sformatf("big len w%0d", i), got[i], exp_q[i]);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post-reset busy", busy, 1'b0);
    check("post-reset wr_en", wr_en, 1'b0);
    check("post-reset body_rd", body_rd, 1'b0);
    check("post-reset dout", dout, 16'h0000);
    idle_quiet("abandoned packet stays dead", 10);
    run_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 64'h1, 64'h0, 64'h0, 0, 0, bc, rc, b0);
    exp_q = ref_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 1'b0);
    cmp_seq("after reset", got, exp_q);

    // Back-to-back: start held high, next packet accepted in the IDLE cycle.
    run_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0, 0, bc, rc, b0);
    cmp_seq("b2b first", got, exp_q);
    run_pkt(8'h03, 16'hCDAB, 24'd4, body_q, 64'h1, 64'h0, 64'h0, 0, 0, bc, rc, b0);
    check("b2b one-cycle gap", b0, 1'b1);
    check("b2b busy cycles", bc, 11);
    cmp_seq("b2b second", got, exp_q);

    for (int r = 0; r < 25; r++) begin
      rt   = 8'($urandom);
      rid  = 16'($urandom);
      rlen = 24'($urandom_range(0, 40));
      body_q.delete();
      for (int i = 0; i < int'(rlen >> 1); i++) body_q.push_back(16'($urandom));
      run_pkt(rt, rid, rlen, body_q, 64'h1, 64'h0, 64'h0, 25, 25, bc, rc, b0);
      exp_q = ref_pkt(rt, rid, rlen, body_q, 1'b0);
      cmp_seq($sformatf("rand%0d", r), got, exp_q);
      exp_q = ref_pkt(rt, rid, rlen, body_q, 1'b1);
      cmp_seq($sformatf("rand%0d nocsum", r), got_nc, exp_q);
      check($sformatf("rand%0d body_rd count", r), rc, int'(rlen >> 1));
    end

    cnt = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
